// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int OVERSAMPLE     = 16;
  localparam int SAMPLE_MID     = 7;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    PARITY     = 3'd3,
    STOP       = 3'd4,
    BREAK_WAIT = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick: one-clk pulse every BAUD_DIV clocks.
module uart_baud_tick #(
  parameter int BAUD_DIV = 27
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_byte.sv
// 16x oversampling UART receiver (8N1 / 8E1 / 8O1) with single-clk byte strobe
// on Empty and one-clk error pulses for framing and parity failures.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int UART_DATA_WIDTH = uart_pkg::DEF_DATA_WIDTH,
  parameter int BAUD_DIV        = 27,
  parameter int PARITY_EN       = 0,
  parameter int PARITY_ODD      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       RXD,
  output logic [UART_DATA_WIDTH-1:0] RXD_Data,
  output logic                       Empty,
  output logic                       Frame_Error,
  output logic                       Parity_Error,
  output logic [2:0]                 dbg_state
);

  localparam int BW = (UART_DATA_WIDTH > 1) ? $clog2(UART_DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_WIDTH - 1);
  localparam logic          ODD      = (PARITY_ODD != 0);

  logic                       sync1;
  logic                       rx_s;
  logic                       tick;
  rx_state_e                  state;
  logic [3:0]                 sample_cnt;
  logic [BW-1:0]              bit_cnt;
  logic [UART_DATA_WIDTH-1:0] shift_reg;
  logic                       parity_bit;
  logic                       parity_ok;
  logic                       start_mid;
  logic                       bit_end;

  uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= RXD;
      rx_s  <= sync1;
    end
  end

  // The START mid-bit clears the sample counter, so from then on a full
  // 16-tick wrap lands on the centre of each following bit.
  assign start_mid = tick && (sample_cnt == 4'(SAMPLE_MID));
  assign bit_end   = tick && (sample_cnt == 4'(OVERSAMPLE - 1));

  always_comb begin
    parity_ok = 1'b1;
    if (PARITY_EN != 0) parity_ok = ((^shift_reg) ^ parity_bit ^ ODD) == 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sample_cnt   <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      parity_bit   <= 1'b0;
      RXD_Data     <= '0;
      Empty        <= 1'b1;
      Frame_Error  <= 1'b0;
      Parity_Error <= 1'b0;
    end else begin
      Empty        <= 1'b1;
      Frame_Error  <= 1'b0;
      Parity_Error <= 1'b0;
      if (tick) sample_cnt <= sample_cnt + 1'b1;
      case (state)
        IDLE: begin
          sample_cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (start_mid) begin
            sample_cnt <= '0;
            bit_cnt    <= '0;
            state      <= rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_reg <= {rx_s, shift_reg[UART_DATA_WIDTH-1:1]};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt    <= '0;
              sample_cnt <= '0;
              state      <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            parity_bit <= rx_s;
            sample_cnt <= '0;
            state      <= STOP;
          end
        end
        STOP: begin
          // Leave at the stop-bit centre to gain half a bit of start-bit margin.
          if (bit_end) begin
            sample_cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              if (parity_ok) begin
                RXD_Data <= shift_reg;
                Empty    <= 1'b0;
              end else begin
                Parity_Error <= 1'b1;
              end
            end else begin
              Frame_Error <= 1'b1;
              state       <= BREAK_WAIT;
            end
          end
        end
        BREAK_WAIT: begin
          sample_cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Randomised bench for uart_rx_byte: an 8N1 and an 8E1 receiver checked every
// cycle against a frame-level model of expected byte / error events.
module tb_uart_rx_byte;
  import uart_pkg::*;

  localparam int BD      = 2;
  localparam int BIT_CLK = 16 * BD;
  localparam logic [1:0] K_OK = 2'd0, K_FE = 2'd1, K_PE = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } ev_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd0 = 1'b1;
  logic rxd1 = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] data0, data1;
  logic       empty0, empty1, fe0, fe1, pe0, pe1;
  logic [2:0] dbg0, dbg1;

  uart_rx_byte #(.UART_DATA_WIDTH(8), .BAUD_DIV(BD), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .clk(clk), .rst(rst), .RXD(rxd0), .RXD_Data(data0), .Empty(empty0),
    .Frame_Error(fe0), .Parity_Error(pe0), .dbg_state(dbg0)
  );

  uart_rx_byte #(.UART_DATA_WIDTH(8), .BAUD_DIV(BD), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst(rst), .RXD(rxd1), .RXD_Data(data1), .Empty(empty1),
    .Frame_Error(fe1), .Parity_Error(pe1), .dbg_state(dbg1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  int   n_checks = 0;
  int   n_fail   = 0;
  ev_t  exp_q0[$];
  ev_t  exp_q1[$];
  logic [7:0] hold0 = 8'h00;
  logic [7:0] hold1 = 8'h00;
  logic [7:0] got0[$];
  logic [7:0] got1[$];
  int   got_cyc0[$];
  int   n_fe0 = 0, n_fe1 = 0, n_pe0 = 0, n_pe1 = 0;
  bit   pend_rst = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level reference: stop bit first, then parity over data + parity bit.
  function automatic logic [1:0] classify(input logic [7:0] d, input bit par_en,
                                          input bit par_odd, input logic par_bit,
                                          input logic stop);
    if (!stop) return K_FE;
    if (par_en && ((($countones(d) + int'(par_bit) + int'(par_odd)) % 2) != 0)) return K_PE;
    return K_OK;
  endfunction

  task automatic observe(input int id, input logic [7:0] d, input logic e,
                         input logic fe, input logic pe);
    ev_t        ev;
    logic [7:0] hold;
    logic [1:0] kind;
    int         npulse;
    hold   = (id == 0) ? hold0 : hold1;
    npulse = int'(!e) + int'(fe) + int'(pe);
    check("pulse_exclusive", 32'(npulse <= 1), 32'd1);
    if (npulse != 0) begin
      if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
        check($sformatf("unexpected_pulse_dut%0d", id), 32'({!e, fe, pe}), 32'd0);
      end else begin
        ev   = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        kind = !e ? K_OK : (fe ? K_FE : K_PE);
        check($sformatf("event_kind_dut%0d", id), 32'(kind), 32'(ev.kind));
        if (!e) begin
          hold = ev.data;
          if (id == 0) begin got0.push_back(d); got_cyc0.push_back(cyc); end
          else got1.push_back(d);
        end
        if (fe) begin if (id == 0) n_fe0++; else n_fe1++; end
        if (pe) begin if (id == 0) n_pe0++; else n_pe1++; end
      end
    end
    check($sformatf("rxd_data_dut%0d", id), 32'(d), 32'(hold));
    if (id == 0) hold0 = hold; else hold1 = hold;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      pend_rst = 1'b1;
    end else begin
      if (pend_rst) begin
        hold0    = 8'h00;
        hold1    = 8'h00;
        pend_rst = 1'b0;
      end
      observe(0, data0, empty0, fe0, pe0);
      observe(1, data1, empty1, fe1, pe1);
    end
  end

  // driver tasks (inputs change 1 time unit after a rising edge)
  task automatic hold_line(input int id, input logic b, input int n);
    if (id == 0) rxd0 = b; else rxd1 = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int id, input logic [7:0] d, input logic par_bit,
                            input logic stop);
    ev_t ev;
    ev.kind = classify(d, (id == 1), 1'b0, par_bit, stop);
    ev.data = d;
    if (id == 0) exp_q0.push_back(ev); else exp_q1.push_back(ev);
    hold_line(id, 1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) hold_line(id, d[i], BIT_CLK);
    if (id == 1) hold_line(id, par_bit, BIT_CLK);
    hold_line(id, stop, BIT_CLK);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int       t0;
    int       sz;
    int       fe_before;
    int       lat;
    int       id;
    int       r;
    logic [7:0] d;
    logic       stop;
    logic       par;

    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_data0", 32'(data0), 32'h0);
    check("reset_empty0", 32'(empty0), 32'd1);
    check("reset_fe0", 32'(fe0), 32'd0);
    check("reset_pe0", 32'(pe0), 32'd0);
    check("reset_state0", 32'(dbg0), 32'(IDLE));
    check("reset_empty1", 32'(empty1), 32'd1);
    check("reset_state1", 32'(dbg1), 32'(IDLE));
    @(posedge clk);
    #1;
    hold_line(0, 1'b1, BIT_CLK);

    // model pins
    check("model_pin_even_ok", 32'(classify(8'h5F, 1'b1, 1'b0, 1'b0, 1'b1)), 32'(K_OK));
    check("model_pin_even_bad", 32'(classify(8'h5F, 1'b1, 1'b0, 1'b1, 1'b1)), 32'(K_PE));
    check("model_pin_stop0", 32'(classify(8'h5F, 1'b1, 1'b0, 1'b0, 1'b0)), 32'(K_FE));

    // back-to-back 0x0A, 0x5A with latency measurement on the first
    t0 = cyc;
    send_frame(0, 8'h0A, 1'b0, 1'b1);
    send_frame(0, 8'h5A, 1'b0, 1'b1);
    hold_line(0, 1'b1, BIT_CLK);
    check("b2b_count", 32'(got0.size()), 32'd2);
    if (got0.size() >= 2) begin
      check("b2b_first", 32'(got0[0]), 32'h0A);
      check("b2b_second", 32'(got0[1]), 32'h5A);
      lat = got_cyc0[0] - t0;
      check("latency_window", 32'(lat >= 305 && lat <= 309), 32'd1);
    end
    check("b2b_no_fe", 32'(n_fe0), 32'd0);

    // start glitch
    sz = got0.size();
    hold_line(0, 1'b0, 8);
    hold_line(0, 1'b1, BIT_CLK);
    @(negedge clk);
    check("glitch_state_idle", 32'(dbg0), 32'(IDLE));
    check("glitch_no_byte", 32'(got0.size()), 32'(sz));
    @(posedge clk);
    #1;
    send_frame(0, 8'h1A, 1'b0, 1'b1);
    hold_line(0, 1'b1, BIT_CLK);
    check("after_glitch_byte", 32'(got0[$]), 32'h1A);

    // framing error then recovery
    fe_before = n_fe0;
    sz        = got0.size();
    send_frame(0, 8'h3A, 1'b0, 1'b0);
    hold_line(0, 1'b0, 3 * BIT_CLK);
    hold_line(0, 1'b1, BIT_CLK);
    check("frame_err_count", 32'(n_fe0 - fe_before), 32'd1);
    check("frame_err_no_byte", 32'(got0.size()), 32'(sz));
    check("frame_err_data_kept", 32'(data0), 32'h1A);
    send_frame(0, 8'h50, 1'b0, 1'b1);
    hold_line(0, 1'b1, BIT_CLK);
    check("after_fe_byte", 32'(got0[$]), 32'h50);

    // even parity receiver
    send_frame(1, 8'h5F, 1'b0, 1'b1);
    hold_line(1, 1'b1, BIT_CLK);
    check("parity_ok_byte", 32'(got1.size() > 0 ? got1[$] : 8'hxx), 32'h5F);
    send_frame(1, 8'h5F, 1'b1, 1'b1);
    hold_line(1, 1'b1, BIT_CLK);
    check("parity_err_count", 32'(n_pe1), 32'd1);
    check("parity_err_data_kept", 32'(data1), 32'h5F);

    // reset in the middle of 0x2A, after data bit 3
    sz = got0.size();
    fe_before = n_fe0;
    d = 8'h2A;
    hold_line(0, 1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) hold_line(0, d[i], BIT_CLK);
    rxd0 = 1'b1;
    pulse_reset();
    hold_line(0, 1'b1, 2 * BIT_CLK);
    check("rst_mid_no_byte", 32'(got0.size()), 32'(sz));
    check("rst_mid_no_fe", 32'(n_fe0), 32'(fe_before));
    check("rst_mid_data_zero", 32'(data0), 32'h0);
    check("rst_mid_state_idle", 32'(dbg0), 32'(IDLE));
    send_frame(0, 8'h00, 1'b0, 1'b1);
    hold_line(0, 1'b1, BIT_CLK);
    check("rst_next_count", 32'(got0.size()), 32'(sz + 1));
    check("rst_next_byte", 32'(got0[$]), 32'h00);

    // randomised traffic on both receivers
    for (int k = 0; k < 40; k++) begin
      id   = int'($urandom_range(0, 1));
      d    = 8'($urandom_range(0, 255));
      r    = int'($urandom_range(0, 9));
      stop = (r != 0);
      par  = (id == 1 && r == 1) ? ~(^d) : ^d;
      send_frame(id, d, par, stop);
      if (!stop) begin
        hold_line(id, 1'b0, int'($urandom_range(0, 64)));
        hold_line(id, 1'b1, BIT_CLK);
      end else begin
        hold_line(id, 1'b1, int'($urandom_range(0, 40)));
      end
    end
    hold_line(0, 1'b1, 2 * BIT_CLK);
    check("drain_q0", 32'(exp_q0.size()), 32'd0);
    check("drain_q1", 32'(exp_q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
